// File: rtl/color_unscra_stream.sv
// color_unscra_stream
// Receiver-side inverse of the RGB channel scrambler for a 24-bit pixel stream.
// The scrambler placed source channel SWx into scrambled slot x.  This block
// finds, for every original channel, the first slot (R, G, B order) that
// carries it.  Channels that did not survive are driven with FILL and flagged
// in m_lossy.  A 2-entry skid buffer decouples m_ready from s_ready.
//
// Optional feature: define COLOR_UNSCRA_STATS_EN to build the per-frame
// saturating lossy-pixel counter.  Without it lossy_cnt is tied to zero.
module color_unscra_stream #(
    parameter logic [7:0]  FILL  = 8'h00,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [23:0]      s_data,
    input  logic             s_sof,
    input  logic [1:0]       SWR,
    input  logic [1:0]       SWG,
    input  logic [1:0]       SWB,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [23:0]      m_data,
    output logic             m_sof,
    output logic [2:0]       m_lossy,
    output logic [CNT_W-1:0] lossy_cnt
);

    // Skid buffer occupancy: EMPTY = no output, ONE = output register only,
    // FULL = output register plus skid register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Scrambler selects, one per scrambled slot.
    typedef struct packed {
        logic [1:0] swr;
        logic [1:0] swg;
        logic [1:0] swb;
    } cfg_t;

    // One recovered pixel as it travels through the buffer.
    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic [2:0]  lossy;
    } beat_t;

    localparam cfg_t CFG_IDENTITY = '{swr: 2'd0, swg: 2'd1, swb: 2'd2};

    // Inverse channel map.  Slot 0 is s_data[23:16] (R), slot 2 is s_data[7:0].
    // Output channel k lands in byte (2-k) of the pixel and bit (2-k) of the
    // lossy mask so both read {R,G,B} from MSB to LSB.
    function automatic beat_t unscramble(
        input logic [23:0] data,
        input logic        sof,
        input cfg_t        cfg
    );
        logic [1:0] sel      [3];
        logic [7:0] byte_in  [3];
        logic [7:0] byte_out [3];
        logic [2:0] hit;
        beat_t      b;

        sel[0]     = cfg.swr;
        sel[1]     = cfg.swg;
        sel[2]     = cfg.swb;
        byte_in[0] = data[23:16];
        byte_in[1] = data[15:8];
        byte_in[2] = data[7:0];

        for (int k = 0; k < 3; k++) begin
            byte_out[k] = FILL;
            hit[k]      = 1'b0;
            // First matching slot wins; select 3 never equals k, so it recovers nothing.
            for (int j = 0; j < 3; j++) begin
                if (!hit[k] && (sel[j] == k[1:0])) begin
                    byte_out[k] = byte_in[j];
                    hit[k]      = 1'b1;
                end
            end
        end

        b.data  = {byte_out[0], byte_out[1], byte_out[2]};
        b.sof   = sof;
        b.lossy = {~hit[0], ~hit[1], ~hit[2]};
        return b;
    endfunction

    state_e state_q, state_d;
    cfg_t   cfg_q, cfg_d;
    beat_t  out_q, out_d;
    beat_t  skid_q, skid_d;
    beat_t  in_beat;
    logic   m_valid_q, m_valid_d;
    logic   s_ready_q, s_ready_d;
    logic   accept;
    logic   drain;

    assign accept = s_valid && s_ready_q;
    assign drain  = m_valid_q && m_ready;

    // Select latch: a new configuration takes effect on the sof beat itself.
    always_comb begin
        cfg_d = cfg_q;
        if (accept && s_sof) begin
            cfg_d = '{swr: SWR, swg: SWG, swb: SWB};
        end
        in_beat = unscramble(s_data, s_sof, cfg_d);
    end

    // Skid buffer next-state: decide where an accepted beat goes and what drains.
    always_comb begin
        // NOTE: every target gets a default first so no path through the case infers a latch.
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = in_beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    skid_d  = in_beat;
                    state_d = ST_FULL;
                end else if (drain && !accept) begin
                    state_d = ST_EMPTY;
                end else if (accept && drain) begin
                    out_d   = in_beat;
                end
            end
            ST_FULL: begin
                // s_ready is low in FULL, so nothing can be accepted here.
                if (drain) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Handshake flags are registered copies of the next occupancy, so
        // m_ready never reaches s_ready combinationally.
        m_valid_d = (state_d != ST_EMPTY);
        s_ready_d = (state_d != ST_FULL);
    end

    // FSM state, configuration and registered output beat.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q   <= ST_EMPTY;
            cfg_q     <= CFG_IDENTITY;
            out_q     <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            out_q     <= out_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
        end
    end

    // Skid payload register.
    always_ff @(posedge clk) begin
        // NOTE: the skid payload has no reset; its contents are only read when the state says FULL.
        skid_q <= skid_d;
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = out_q.data;
    assign m_sof   = out_q.sof;
    assign m_lossy = out_q.lossy;

`ifdef COLOR_UNSCRA_STATS_EN
    logic [CNT_W-1:0] lossy_cnt_q, lossy_cnt_d;

    // Per-frame lossy counter: restarts on a drained sof beat, saturates at all ones.
    always_comb begin
        lossy_cnt_d = lossy_cnt_q;
        if (drain) begin
            if (out_q.sof) begin
                lossy_cnt_d    = '0;
                lossy_cnt_d[0] = |out_q.lossy;
            end else if ((|out_q.lossy) && (lossy_cnt_q != {CNT_W{1'b1}})) begin
                lossy_cnt_d = lossy_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lossy_cnt_q <= '0;
        end else begin
            lossy_cnt_q <= lossy_cnt_d;
        end
    end

    assign lossy_cnt = lossy_cnt_q;
`else
    assign lossy_cnt = '0;
`endif

endmodule

// File: tb/tb_color_unscra_stream.sv
// Directed bench for color_unscra_stream: a table of single-beat vectors with
// hand-computed results, then hand-written backpressure, counter-saturation
// and reset-while-full sequences.  The DUT counter is narrowed to 4 bits so
// saturation is reachable quickly.
module tb_color_unscra_stream;

    localparam int CW = 4;

`ifdef COLOR_UNSCRA_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [23:0]   s_data;
    logic          s_sof;
    logic [1:0]    SWR, SWG, SWB;
    logic          m_valid;
    logic          m_ready;
    logic [23:0]   m_data;
    logic          m_sof;
    logic [2:0]    m_lossy;
    logic [CW-1:0] lossy_cnt;

    int total = 0;
    int bad   = 0;

    color_unscra_stream #(
        .FILL (8'h00),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .SWR      (SWR),
        .SWG      (SWG),
        .SWB      (SWB),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_sof    (m_sof),
        .m_lossy  (m_lossy),
        .lossy_cnt(lossy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  sw;        // {SWR,SWG,SWB}
        logic        sof;
        logic [23:0] data;
        logic [23:0] exp_data;
        logic [2:0]  exp_lossy;
        int          exp_cnt;   // counter after this beat drains (stats build)
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    // Called at a negedge with m_ready=1 and the buffer empty: one beat in,
    // check it on the output, let it drain, check the counter.
    task automatic run_vec(input vec_t v, input string tag);
        s_valid = 1'b1;
        s_sof   = v.sof;
        s_data  = v.data;
        {SWR, SWG, SWB} = v.sw;
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b1;
        s_data  = ~v.data;
        {SWR, SWG, SWB} = ~v.sw;
        check({tag, " m_valid"}, 32'(m_valid), 32'd1);
        check({tag, " m_data"},  32'(m_data),  32'(v.exp_data));
        check({tag, " m_lossy"}, 32'(m_lossy), 32'(v.exp_lossy));
        check({tag, " m_sof"},   32'(m_sof),   32'(v.sof));
        @(negedge clk);
        check({tag, " drained"}, 32'(m_valid), 32'd0);
        check({tag, " cnt"},     32'(lossy_cnt), cnt_exp(v.exp_cnt));
    endtask

    initial begin
        vec_t v;

        vecs[0]  = '{6'b00_01_10, 1'b1, 24'h112233, 24'h112233, 3'b000, 0};
        vecs[1]  = '{6'b01_10_00, 1'b1, 24'hAABBCC, 24'hCCAABB, 3'b000, 0};
        vecs[2]  = '{6'b00_00_11, 1'b1, 24'h5A5A00, 24'h5A0000, 3'b011, 1};
        vecs[3]  = '{6'b01_10_00, 1'b0, 24'h123456, 24'h120000, 3'b011, 2};
        vecs[4]  = '{6'b11_11_11, 1'b1, 24'hFFFFFF, 24'h000000, 3'b111, 1};
        vecs[5]  = '{6'b10_10_10, 1'b1, 24'h010203, 24'h000001, 3'b110, 1};
        vecs[6]  = '{6'b10_00_01, 1'b1, 24'h102030, 24'h203010, 3'b000, 0};
        vecs[7]  = '{6'b00_01_10, 1'b0, 24'h445566, 24'h556644, 3'b000, 0};
        vecs[8]  = '{6'b01_01_00, 1'b1, 24'h778899, 24'h997700, 3'b001, 1};
        vecs[9]  = '{6'b01_01_00, 1'b0, 24'hABCDEF, 24'hEFAB00, 3'b001, 2};
        vecs[10] = '{6'b00_10_11, 1'b1, 24'h0A0B0C, 24'h0A000B, 3'b010, 1};
        vecs[11] = '{6'b00_01_10, 1'b1, 24'hDEADBE, 24'hDEADBE, 3'b000, 0};

        reset   = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = 24'h0;
        {SWR, SWG, SWB} = 6'b00_01_10;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst m_valid", 32'(m_valid),   32'd0);
        check("rst s_ready", 32'(s_ready),   32'd1);
        check("rst m_data",  32'(m_data),    32'd0);
        check("rst m_lossy", 32'(m_lossy),   32'd0);
        check("rst cnt",     32'(lossy_cnt), 32'd0);

        // Table-driven mapping vectors.
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: three beats into a stalled output, then release.
        m_ready = 1'b0;
        s_valid = 1'b1; s_sof = 1'b1; s_data = 24'h010203; {SWR, SWG, SWB} = 6'b00_00_11;
        @(negedge clk);
        check("bp0 m_data",  32'(m_data),  32'h010000);
        check("bp0 m_lossy", 32'(m_lossy), 32'(3'b011));
        check("bp0 s_ready", 32'(s_ready), 32'd1);
        s_sof = 1'b0; s_data = 24'h040506; {SWR, SWG, SWB} = 6'b01_10_00;
        @(negedge clk);
        check("bp1 s_ready", 32'(s_ready), 32'd0);
        check("bp1 m_data",  32'(m_data),  32'h010000);
        s_sof = 1'b1; s_data = 24'h070809; {SWR, SWG, SWB} = 6'b00_01_10;
        @(negedge clk);
        check("bp2 s_ready", 32'(s_ready), 32'd0);
        check("bp2 m_valid", 32'(m_valid), 32'd1);
        check("bp2 m_data",  32'(m_data),  32'h010000);
        check("bp2 m_sof",   32'(m_sof),   32'd1);
        m_ready = 1'b1;
        @(negedge clk);
        check("bp3 m_data",  32'(m_data),    32'h040000);
        check("bp3 m_sof",   32'(m_sof),     32'd0);
        check("bp3 s_ready", 32'(s_ready),   32'd1);
        check("bp3 cnt",     32'(lossy_cnt), cnt_exp(1));
        @(negedge clk);
        s_valid = 1'b0;
        check("bp4 m_data",  32'(m_data),    32'h070809);
        check("bp4 m_lossy", 32'(m_lossy),   32'd0);
        check("bp4 m_sof",   32'(m_sof),     32'd1);
        check("bp4 cnt",     32'(lossy_cnt), cnt_exp(2));
        @(negedge clk);
        check("bp5 m_valid", 32'(m_valid),   32'd0);
        check("bp5 cnt",     32'(lossy_cnt), cnt_exp(0));

        // Counter saturation: a frame of all-lossy pixels.
        for (int i = 0; i < 19; i++) begin
            v = '{6'b11_11_11, (i == 0), 24'(i * 3 + 1), 24'h000000, 3'b111,
                  (i + 1 > 15) ? 15 : i + 1};
            run_vec(v, $sformatf("sat%0d", i));
        end

        // Reset while the buffer is FULL.
        m_ready = 1'b0;
        s_valid = 1'b1; s_sof = 1'b0; s_data = 24'h111111;
        @(negedge clk);
        s_data = 24'h222222;
        @(negedge clk);
        check("full s_ready", 32'(s_ready), 32'd0);
        check("full m_valid", 32'(m_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        check("rf m_valid", 32'(m_valid),   32'd0);
        check("rf s_ready", 32'(s_ready),   32'd1);
        check("rf m_data",  32'(m_data),    32'd0);
        check("rf m_sof",   32'(m_sof),     32'd0);
        check("rf m_lossy", 32'(m_lossy),   32'd0);
        check("rf cnt",     32'(lossy_cnt), 32'd0);
        @(negedge clk);
        check("rf idle", 32'(m_valid), 32'd0);
        // Configuration must be back to identity; non-sof selects are ignored.
        v = '{6'b01_10_00, 1'b0, 24'h123456, 24'h123456, 3'b000, 0};
        run_vec(v, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
